// File: rtl/stream_thread.sv
// stream_thread: instruction-driven thread that fetches from imem and streams
// bmem blocks to a shared UART writer as framed packets (length, address, data).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | not running; waits for running=1 (restarts pc after HALT)
// FETCH    | pc on imem_addr, covers the one-cycle imem latency
// DECODE   | execute HALT / WRITE / JUMP / WAIT
// LOAD     | snapshot the addressed bmem block into the local buffer
// LOCK     | request the UART write lock, wait for grant
// HDR_LEN  | emit frame length field, little-endian
// HDR_ADDR | emit block address field, little-endian
// DATA     | emit buffered block bytes, then one cycle to drain last strobe
// RELEASE  | lock dropped, wait for grant to fall
// WAIT     | count down the WAIT instruction's cycle count

module stream_thread #(
    parameter int                  BITWIDTH    = 32,
    parameter int                  BLOCK_BYTES = 16,
    parameter int                  ADDR_BYTES  = 4,
    parameter int                  LEN_BYTES   = 4,
    parameter logic [BITWIDTH-1:0] PC_RESET    = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     running_i,
    output logic [BITWIDTH-1:0]      imem_addr_o,
    input  logic [BITWIDTH-1:0]      imem_data_i,
    output logic [BITWIDTH-1:0]      bmem_addr_o,
    input  logic [8*BLOCK_BYTES-1:0] bmem_data_i,
    output logic                     write_lock_req_o,
    input  logic                     write_lock_gnt_i,
    input  logic                     write_ready_i,
    output logic [7:0]               write_data_o,
    output logic                     write_data_valid_o,
    output logic                     busy_o,
    output logic                     halted_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_LOAD     = 4'd3;
    localparam logic [3:0] S_LOCK     = 4'd4;
    localparam logic [3:0] S_HDR_LEN  = 4'd5;
    localparam logic [3:0] S_HDR_ADDR = 4'd6;
    localparam logic [3:0] S_DATA     = 4'd7;
    localparam logic [3:0] S_RELEASE  = 4'd8;
    localparam logic [3:0] S_WAIT     = 4'd9;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    localparam int CNTW   = BITWIDTH - 2;
    localparam int LEN_W  = 8 * LEN_BYTES;
    localparam int MAX_LA = (LEN_BYTES > ADDR_BYTES) ? LEN_BYTES : ADDR_BYTES;
    localparam int MAX_F  = (BLOCK_BYTES > MAX_LA) ? BLOCK_BYTES : MAX_LA;
    localparam int CW     = $clog2(MAX_F + 1);

    // Length field counts everything after itself: address plus data.
    localparam logic [LEN_W-1:0] FRAME_LEN = LEN_W'(ADDR_BYTES + BLOCK_BYTES);

    localparam logic [CW-1:0] LEN_LAST  = CW'(LEN_BYTES - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DATA_END  = CW'(BLOCK_BYTES);

    logic [3:0]               state_q,  state_d;
    logic [BITWIDTH-1:0]      pc_q,     pc_d;
    logic [BITWIDTH-1:0]      baddr_q,  baddr_d;
    logic [8*BLOCK_BYTES-1:0] blk_q,    blk_d;
    logic [CNTW-1:0]          wait_q,   wait_d;
    logic [CW-1:0]            bctr_q,   bctr_d;
    logic [7:0]               wdata_q,  wdata_d;
    logic                     wvalid_q, wvalid_d;
    logic                     halted_q, halted_d;

    logic [1:0]          op;
    logic [BITWIDTH-1:0] arg;
    logic [CNTW-1:0]     count;
    logic [BITWIDTH-1:0] jump_pc;
    logic [7:0]          len_byte;
    logic [7:0]          addr_byte;
    logic [7:0]          data_byte;

    // Instruction field split and per-field byte selection by byte counter.
    always_comb begin
        op        = imem_data_i[1:0];
        arg       = {imem_data_i[BITWIDTH-1:2], 2'b00};
        count     = imem_data_i[BITWIDTH-1:2];
        jump_pc   = {2'b00, imem_data_i[BITWIDTH-1:2]};
        len_byte  = 8'(FRAME_LEN >> {bctr_q, 3'b000});
        addr_byte = 8'(baddr_q >> {bctr_q, 3'b000});
        data_byte = 8'(blk_q >> {bctr_q, 3'b000});
    end

    // Next-state logic for the thread FSM and all datapath registers.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        baddr_d  = baddr_q;
        blk_d    = blk_q;
        wait_d   = wait_q;
        bctr_d   = bctr_q;
        wdata_d  = wdata_q;
        wvalid_d = 1'b0;
        halted_d = halted_q;

        case (state_q)
            S_IDLE: begin
                if (running_i) begin
                    state_d = S_FETCH;
                    if (halted_q) begin
                        pc_d     = PC_RESET;
                        halted_d = 1'b0;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (!running_i) begin
                    state_d = S_IDLE;
                end else begin
                    case (op)
                        OP_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                        OP_WRITE: begin
                            baddr_d = arg;
                            pc_d    = pc_q + BITWIDTH'(1);
                            state_d = S_LOAD;
                        end
                        OP_JUMP: begin
                            pc_d    = jump_pc;
                            state_d = S_FETCH;
                        end
                        OP_WAIT: begin
                            pc_d    = pc_q + BITWIDTH'(1);
                            wait_d  = count;
                            state_d = (count == '0) ? S_FETCH : S_WAIT;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_WAIT: begin
                if (!running_i) begin
                    wait_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - CNTW'(1);
                    if (wait_q == CNTW'(1)) begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_LOAD: begin
                blk_d   = bmem_data_i;
                state_d = S_LOCK;
            end

            S_LOCK: begin
                if (write_lock_gnt_i) begin
                    bctr_d  = '0;
                    state_d = S_HDR_LEN;
                end
            end

            S_HDR_LEN: begin
                if (write_ready_i) begin
                    wdata_d  = len_byte;
                    wvalid_d = 1'b1;
                    if (bctr_q == LEN_LAST) begin
                        bctr_d  = '0;
                        state_d = S_HDR_ADDR;
                    end else begin
                        bctr_d = bctr_q + CW'(1);
                    end
                end
            end

            S_HDR_ADDR: begin
                if (write_ready_i) begin
                    wdata_d  = addr_byte;
                    wvalid_d = 1'b1;
                    if (bctr_q == ADDR_LAST) begin
                        bctr_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        bctr_d = bctr_q + CW'(1);
                    end
                end
            end

            // The extra cycle at DATA_END lets the final byte strobe go out
            // while the lock is still held; RELEASE then has req and valid low.
            S_DATA: begin
                if (bctr_q == DATA_END) begin
                    bctr_d  = '0;
                    state_d = S_RELEASE;
                end else if (write_ready_i) begin
                    wdata_d  = data_byte;
                    wvalid_d = 1'b1;
                    bctr_d   = bctr_q + CW'(1);
                end
            end

            S_RELEASE: begin
                if (!write_lock_gnt_i) begin
                    state_d = running_i ? S_FETCH : S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            baddr_q  <= '0;
            blk_q    <= '0;
            wait_q   <= '0;
            bctr_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            baddr_q  <= baddr_d;
            blk_q    <= blk_d;
            wait_q   <= wait_d;
            bctr_q   <= bctr_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            halted_q <= halted_d;
        end
    end

    // bmem gets the address a cycle early (from DECODE) so a synchronous-read
    // bmem has the block ready by the LOAD cycle.
    always_comb begin
        imem_addr_o        = pc_q;
        bmem_addr_o        = baddr_d;
        write_lock_req_o   = (state_q == S_LOCK)     || (state_q == S_HDR_LEN) ||
                             (state_q == S_HDR_ADDR) || (state_q == S_DATA);
        write_data_o       = wdata_q;
        write_data_valid_o = wvalid_q;
        busy_o             = (state_q != S_IDLE);
        halted_o           = halted_q;
    end

endmodule

// File: tb/tb_stream_thread.sv
// Scoreboard bench for stream_thread: a program-level reference model pushes
// the expected byte stream and fetch trace; a monitor pops and compares.
module tb_stream_thread;

    localparam int BW = 32;
    localparam int BB = 16;
    localparam int AB = 4;
    localparam int LB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          running = 1'b0;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_data = '0;
    logic [31:0]   bmem_addr;
    logic [127:0]  bmem_data = '0;
    logic          req;
    logic          gnt;
    logic          ready = 1'b1;
    logic [7:0]    wdata;
    logic          valid;
    logic          busy;
    logic          halted;

    always #5 clock = ~clock;

    stream_thread #(
        .BITWIDTH(BW), .BLOCK_BYTES(BB), .ADDR_BYTES(AB), .LEN_BYTES(LB), .PC_RESET(32'd0)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .running_i          (running),
        .imem_addr_o        (imem_addr),
        .imem_data_i        (imem_data),
        .bmem_addr_o        (bmem_addr),
        .bmem_data_i        (bmem_data),
        .write_lock_req_o   (req),
        .write_lock_gnt_i   (gnt),
        .write_ready_i      (ready),
        .write_data_o       (wdata),
        .write_data_valid_o (valid),
        .busy_o             (busy),
        .halted_o           (halted)
    );

    logic [31:0] imem [0:63];
    logic [7:0]  salt = 8'd0;
    int          gnt_delay = 0;
    int          req_age = 0;
    int          rdy_mode = 0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    int          exp_trace [$];
    int          got_trace [$];
    int          rx_cnt = 0;
    int          busy_cnt = 0;
    bit          trace_first = 1'b1;
    logic [31:0] last_addr = '0;
    bit          rdy_last = 1'b0;
    bit          gnt_last = 1'b0;
    bit          in_frame = 1'b0;

    function automatic logic [7:0] bm_byte(input logic [31:0] a, input int i);
        return (a[7:0] - 8'h40 + 8'(i)) ^ a[15:8];
    endfunction

    function automatic logic [127:0] blk(input logic [31:0] a, input logic [7:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < BB; i++) r[8*i +: 8] = bm_byte(a, i) ^ s;
        return r;
    endfunction

    assign gnt = req && (req_age >= gnt_delay);

    // Synchronous-read memories and grant-age counter.
    always @(posedge clock) begin
        imem_data <= imem[imem_addr[5:0]];
        bmem_data <= blk(bmem_addr, salt);
        req_age   <= req ? req_age + 1 : 0;
    end

    // UART ready pattern, changed just after the active edge.
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected bytes on every strobe, checks lock protocol,
    // perturbs bmem once a frame is underway, records fetch trace.
    always @(negedge clock) begin
        if (valid) begin
            chk("strobe_under_lock", {61'd0, req, gnt_last, rdy_last}, 64'd7);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got %02h with no byte expected", wdata);
            end else begin
                chk("byte", wdata, exp_q.pop_front());
            end
            rx_cnt++;
            if (!in_frame) begin
                in_frame = 1'b1;
                salt = 8'($urandom_range(1, 255));
            end
        end
        if (!req) begin
            in_frame = 1'b0;
            salt = 8'd0;
        end
        if (busy) begin
            busy_cnt++;
            if (trace_first || imem_addr != last_addr) got_trace.push_back(int'(imem_addr));
            trace_first = 1'b0;
            last_addr = imem_addr;
        end
        rdy_last = ready;
        gnt_last = gnt;
    end

    // Program-level reference: walk imem from start_pc until HALT.
    task automatic model_run(input int start_pc, output int end_pc, output int cyc);
        int pc;
        bit stop;
        logic [31:0] ins;
        logic [31:0] a;
        pc = start_pc;
        stop = 1'b0;
        cyc = 0;
        for (int steps = 0; steps < 64 && !stop; steps++) begin
            ins = imem[pc % 64];
            exp_trace.push_back(pc);
            cyc += 2;
            case (ins % 4)
                0: stop = 1'b1;
                1: begin
                    a = ins - 1;
                    for (int k = 0; k < LB; k++) exp_q.push_back(8'(((AB + BB) >> (8 * k)) % 256));
                    for (int k = 0; k < AB; k++) exp_q.push_back(8'((a >> (8 * k)) % 256));
                    for (int k = 0; k < BB; k++) exp_q.push_back(bm_byte(a, k));
                    pc = pc + 1;
                end
                2: pc = int'(ins / 4);
                default: begin
                    cyc += int'(ins / 4);
                    pc = pc + 1;
                end
            endcase
        end
        end_pc = pc;
    endtask

    task automatic start_run(input int start_pc, output int end_pc, output int cyc, output int nbytes);
        exp_q.delete();
        exp_trace.delete();
        got_trace.delete();
        trace_first = 1'b1;
        rx_cnt = 0;
        busy_cnt = 0;
        model_run(start_pc, end_pc, cyc);
        nbytes = exp_q.size();
        running = 1'b1;
    endtask

    task automatic run_until_halt(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clock);
            if (halted) begin
                running = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: halted still 0 after 4000 cycles, required 1", name);
            running = 1'b0;
        end
    endtask

    task automatic end_checks(input string name, input int end_pc, input int nbytes);
        chk({name, "_bytes_left"}, exp_q.size(), 0);
        chk({name, "_byte_count"}, rx_cnt, nbytes);
        chk({name, "_halted"}, halted, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_req"}, req, 0);
        chk({name, "_pc"}, imem_addr, end_pc);
        chk({name, "_trace_len"}, got_trace.size(), exp_trace.size());
        for (int i = 0; i < exp_trace.size() && i < got_trace.size(); i++)
            chk({name, "_trace"}, got_trace[i], exp_trace[i]);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    initial begin
        int end_pc, cyc, nb, pc, skip, r;
        bit ok;

        clear_imem();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_bmem_addr", bmem_addr, 0);
        chk("rst_wdata", wdata, 0);

        // Basic WRITE then HALT, ready always high, grant immediate.
        clear_imem();
        imem[0] = 32'h0000_0041;
        imem[1] = 32'h0;
        rdy_mode = 0;
        gnt_delay = 0;
        @(negedge clock);
        start_run(0, end_pc, cyc, nb);
        chk("basic_frame_size", nb, 24);
        run_until_halt("basic");
        end_checks("basic", end_pc, nb);

        // Same program with ready toggling.
        @(negedge clock);
        rdy_mode = 1;
        start_run(0, end_pc, cyc, nb);
        run_until_halt("toggle");
        end_checks("toggle", end_pc, nb);

        // Grant delayed by 10 cycles.
        @(negedge clock);
        rdy_mode = 0;
        gnt_delay = 10;
        start_run(0, end_pc, cyc, nb);
        run_until_halt("gnt_delay");
        end_checks("gnt_delay", end_pc, nb);
        gnt_delay = 0;

        // WAIT 5, JUMP to word 3 (word 2 is a trap WRITE), HALT.
        @(negedge clock);
        clear_imem();
        imem[0] = 32'h0000_0017;
        imem[1] = 32'h0000_000E;
        imem[2] = 32'h0000_0041;
        imem[3] = 32'h0;
        start_run(0, end_pc, cyc, nb);
        run_until_halt("wait_jump");
        end_checks("wait_jump", end_pc, nb);
        chk("wait_jump_busy_cycles", busy_cnt, cyc);

        // running dropped at the 6th data byte: frame completes, thread idles at pc=1.
        @(negedge clock);
        clear_imem();
        imem[0] = 32'h0000_0041;
        imem[1] = 32'h0;
        start_run(0, end_pc, cyc, nb);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (rx_cnt >= LB + AB + 6) ok = 1'b1;
        end
        chk("drop_reached_byte", ok, 1);
        running = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (!busy) ok = 1'b1;
        end
        chk("drop_went_idle", ok, 1);
        chk("drop_bytes_left", exp_q.size(), 0);
        chk("drop_byte_count", rx_cnt, 24);
        chk("drop_req", req, 0);
        chk("drop_halted", halted, 0);
        chk("drop_pc", imem_addr, 1);
        @(negedge clock);
        start_run(1, end_pc, cyc, nb);
        run_until_halt("resume");
        end_checks("resume", end_pc, nb);

        // Reset in the middle of the header, then a fresh frame.
        @(negedge clock);
        clear_imem();
        imem[0] = 32'h0000_1235;
        imem[1] = 32'h0;
        start_run(0, end_pc, cyc, nb);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (rx_cnt >= 3) ok = 1'b1;
        end
        chk("midrst_reached_byte", ok, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_req", req, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", imem_addr, 0);
        reset = 1'b0;
        running = 1'b0;
        exp_q.delete();
        @(negedge clock);
        imem[0] = 32'h0000_0081;
        start_run(0, end_pc, cyc, nb);
        run_until_halt("after_rst");
        end_checks("after_rst", end_pc, nb);

        // Randomized forward-only programs with random ready and grant delay.
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            clear_imem();
            pc = 0;
            for (int k = 0, n = $urandom_range(2, 5); k < n; k++) begin
                r = $urandom_range(0, 2);
                if (r == 0) begin
                    imem[pc] = 32'($urandom_range(0, 16'h3FFF) * 4) | 32'd1;
                    pc++;
                end else if (r == 1) begin
                    imem[pc] = 32'($urandom_range(0, 6) * 4) | 32'd3;
                    pc++;
                end else begin
                    skip = $urandom_range(1, 2);
                    imem[pc] = 32'((pc + 1 + skip) * 4) | 32'd2;
                    for (int s = 1; s <= skip; s++) imem[pc + s] = 32'($urandom_range(0, 255) * 4) | 32'd1;
                    pc += 1 + skip;
                end
            end
            imem[pc] = 32'h0;
            rdy_mode = 2;
            gnt_delay = $urandom_range(0, 5);
            start_run(0, end_pc, cyc, nb);
            run_until_halt("rand");
            end_checks("rand", end_pc, nb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_thread.md
Name: stream_thread

Overview:
- Parametrised instruction-driven thread that fetches from imem and executes instructions.
- WRITE streams one block from bmem to the shared UART writer as a framed packet: length, then address, then data.
- Adds over the previous thread: real PC management, JUMP and WAIT opcodes, a configurable block size and header field widths, clean halt/restart, and frame-atomic stop.
- Sits between imem/bmem and the UART write-lock arbiter; several instances share one UART.

Parameters:
- BITWIDTH, 32: imem word, PC and bmem address width.
- BLOCK_BYTES, 16: bytes per bmem block; bmem_data width is 8*BLOCK_BYTES.
- ADDR_BYTES, 4: address field bytes in the header (at most BITWIDTH/8).
- LEN_BYTES, 4: length field bytes in the header.
- PC_RESET, 0: PC value after reset and on restart after HALT.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- running  in  1  enable; level-sensitive.
- imem_addr  out  BITWIDTH  word address, equal to pc.
- imem_data  in  BITWIDTH  instruction; valid 1 cycle after imem_addr.
- bmem_addr  out  BITWIDTH  block address.
- bmem_data  in  8*BLOCK_BYTES  block data; valid 1 cycle after bmem_addr.
- write_lock_req  out  1  UART lock request.
- write_lock_gnt  in  1  UART lock grant.
- write_ready  in  1  UART accepts a byte this cycle.
- write_data  out  8  byte to the UART.
- write_data_valid  out  1  byte strobe.
- busy  out  1  high when the state is not IDLE.
- halted  out  1  set by HALT; cleared on restart.

Behaviour:
- Reset: clock is clock; reset is synchronous, active-high, and reset is reset.
  - On reset: state=IDLE, pc=PC_RESET, bmem_addr=0, write_lock_req=0, write_data=0, write_data_valid=0, busy=0, halted=0, wait counter=0.
  - Reset mid-frame abandons the frame immediately; req and valid are low on the next cycle.
- Instruction encoding: op=imem_data[1:0]; arg={imem_data[BITWIDTH-1:2],2'b00}, except WAIT, which uses imem_data[BITWIDTH-1:2] as a count.
  - 00 HALT, 01 WRITE, 10 JUMP, 11 WAIT.
- States: IDLE, FETCH, DECODE, LOAD, LOCK, HDR_LEN, HDR_ADDR, DATA, RELEASE, WAIT.
- IDLE -> FETCH when running=1. If halted=1, pc<=PC_RESET and halted<=0 on that transition.
- FETCH: exactly 1 cycle covering imem latency -> DECODE.
- DECODE (running=0 -> IDLE, pc unchanged):
  - HALT: halted<=1, pc unchanged, -> IDLE.
  - WRITE: bmem_addr<=arg, pc<=pc+1, -> LOAD.
  - JUMP: pc<=arg>>2 (pc is a word index), -> FETCH.
  - WAIT: pc<=pc+1, ctr<=count. If count=0 -> FETCH, else -> WAIT.
- WAIT: decrement ctr each cycle; at ctr=1 -> FETCH. running=0 -> IDLE, dropping the wait.
- LOAD: 1 cycle; capture bmem_data into the block buffer -> LOCK.
  - The block is snapshotted before the lock, so bmem changes during streaming do not affect the frame.
- LOCK: write_lock_req=1; hold until write_lock_gnt=1, then byte ctr=0 -> HDR_LEN.
- Byte emission in HDR_LEN, HDR_ADDR and DATA:
  - On a cycle with write_ready=1, the byte is registered with write_data_valid=1 for exactly one cycle; otherwise valid=0.
  - Ctr advances only on emitted bytes.
  - All fields are little-endian.
- HDR_LEN: emits LEN_BYTES bytes of (ADDR_BYTES+BLOCK_BYTES), truncated or zero-extended to 8*LEN_BYTES, then -> HDR_ADDR.
- HDR_ADDR: emits the low ADDR_BYTES bytes of bmem_addr, then -> DATA.
- DATA: emits buffer bytes 0..BLOCK_BYTES-1, then -> RELEASE.
- Frame length is always LEN_BYTES+ADDR_BYTES+BLOCK_BYTES bytes; no gap cycles are required between bytes.
- RELEASE: write_lock_req=0 and valid=0; wait until write_lock_gnt=0.
  - Then -> FETCH if running=1, else -> IDLE.
- running=0 during LOAD through DATA does not truncate the frame; the frame completes and then goes to IDLE.
- write_lock_req stays high continuously from LOCK entry until RELEASE entry.
- pc wraps modulo 2^BITWIDTH.
- write_data holds its last value when valid=0.
- Latency: WRITE instruction to first byte = FETCH + DECODE + LOAD + LOCK (>=1) + 1 = at least 5 cycles.

Test Plan:
- Defaults; imem[0]=WRITE 0x40, imem[1]=HALT; bmem block 0x40=bytes 0x00..0x0F; gnt tied to req; ready=1; running=1 -> 24 bytes: 14 00 00 00, 40 00 00 00, 00..0F; then halted=1, busy=0, req=0.
- Same program with write_ready toggling 1,0,1,0 -> the same 24 bytes, valid only on ready cycles, req high throughout the frame.
- Grant delayed 10 cycles -> req held high, no valid pulses until the cycle after gnt, then the identical frame.
- imem[0]=WAIT 5, imem[1]=JUMP 0x0C, imem[3]=HALT -> imem_addr sequence 0,1,3; exactly 5 WAIT cycles; halted=1; imem_addr=3.
- running dropped at the 6th data byte -> the frame completes all 24 bytes, req drops, state IDLE, pc=1. running raised again -> pc=1 resumes, HALT.
- Reset asserted at the 3rd header byte -> the next cycle has req=0, valid=0, busy=0, pc=0. Rerunning produces a complete, fresh frame.
